// File: rtl/gf_sample_sequencer.sv
// gf_sample_sequencer
//   Sequences a bank of 3-tap glitch filters. For every group it produces the
//   synchronous clear, a programmable-rate sample-enable pulse, and a valid
//   flag that rises once the filter pipeline has been flushed.
//
// Ports
//   iClk        core clock, rising edge
//   iRst        asynchronous active-high reset
//   iGlobalEna  1 = period/fill counting runs, 0 = counters freeze
//   iPeriod     per-group period P at [g*CNT_WIDTH +: CNT_WIDTH]; pulses every P+1 cycles
//   iReinit     per-group single-cycle re-initialisation request
//   oSRst_n     per-group active-low synchronous clear to the filter
//   oEna        per-group one-cycle sample-enable pulse
//   oValid      per-group filter output valid
//   oBusy       1 while any group is not in RUN
module gf_sample_sequencer #(
  parameter int unsigned NUM_GROUPS  = 4,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned CLR_CYCLES  = 4,
  parameter int unsigned FILL_PULSES = 3
) (
  input  logic                              iClk,
  input  logic                              iRst,
  input  logic                              iGlobalEna,
  input  logic [NUM_GROUPS*CNT_WIDTH-1:0]   iPeriod,
  input  logic [NUM_GROUPS-1:0]             iReinit,
  output logic [NUM_GROUPS-1:0]             oSRst_n,
  output logic [NUM_GROUPS-1:0]             oEna,
  output logic [NUM_GROUPS-1:0]             oValid,
  output logic                              oBusy
);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [7:0]           CLR_LAST  = 8'(CLR_CYCLES - 1);
  localparam logic [3:0]           FILL_LAST = 4'(FILL_PULSES - 1);
  localparam logic [3:0]           FILL_SAT  = 4'(FILL_PULSES);
  localparam logic [CNT_WIDTH-1:0] PER_ONE   = CNT_WIDTH'(1);

  state_t               state    [NUM_GROUPS];
  state_t               stateNxt [NUM_GROUPS];
  logic [7:0]           clrCnt   [NUM_GROUPS];
  logic [7:0]           clrNxt   [NUM_GROUPS];
  logic [CNT_WIDTH-1:0] perCnt   [NUM_GROUPS];
  logic [CNT_WIDTH-1:0] perNxt   [NUM_GROUPS];
  logic [3:0]           fillCnt  [NUM_GROUPS];
  logic [3:0]           fillNxt  [NUM_GROUPS];
  logic [NUM_GROUPS-1:0] srstNxt;
  logic [NUM_GROUPS-1:0] enaNxt;
  logic [NUM_GROUPS-1:0] validNxt;
  logic                  busyNxt;

  always_comb begin
    busyNxt = 1'b0;
    for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
      stateNxt[g] = state[g];
      clrNxt[g]   = clrCnt[g];
      perNxt[g]   = perCnt[g];
      fillNxt[g]  = fillCnt[g];
      srstNxt[g]  = oSRst_n[g];
      enaNxt[g]   = 1'b0;
      validNxt[g] = oValid[g];

      if (iReinit[g]) begin
        // Reinit wins over everything, including a pulse due this cycle.
        stateNxt[g] = CLEAR;
        clrNxt[g]   = '0;
        srstNxt[g]  = 1'b0;
        validNxt[g] = 1'b0;
      end else begin
        unique case (state[g])
          CLEAR: begin
            if (clrCnt[g] == CLR_LAST) begin
              stateNxt[g] = FILL;
              srstNxt[g]  = 1'b1;
              perNxt[g]   = iPeriod[g*CNT_WIDTH +: CNT_WIDTH];
              fillNxt[g]  = '0;
            end else begin
              clrNxt[g] = clrCnt[g] + 8'd1;
            end
          end
          FILL, RUN: begin
            if (iGlobalEna) begin
              if (perCnt[g] == '0) begin
                enaNxt[g] = 1'b1;
                perNxt[g] = iPeriod[g*CNT_WIDTH +: CNT_WIDTH];
              end else begin
                perNxt[g] = perCnt[g] - PER_ONE;
              end
              // Fill counting looks at the pulse currently on oEna, so valid
              // rises the cycle after the last flushing pulse.
              if (state[g] == FILL && oEna[g]) begin
                if (fillCnt[g] == FILL_LAST) begin
                  stateNxt[g] = RUN;
                  validNxt[g] = 1'b1;
                  fillNxt[g]  = FILL_SAT;
                end else begin
                  fillNxt[g] = fillCnt[g] + 4'd1;
                end
              end
            end
          end
          default: begin
            stateNxt[g] = CLEAR;
            clrNxt[g]   = '0;
            srstNxt[g]  = 1'b0;
            validNxt[g] = 1'b0;
          end
        endcase
      end

      if (stateNxt[g] != RUN) busyNxt = 1'b1;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
        state[g]   <= CLEAR;
        clrCnt[g]  <= '0;
        perCnt[g]  <= '0;
        fillCnt[g] <= '0;
      end
      oSRst_n <= '0;
      oEna    <= '0;
      oValid  <= '0;
      oBusy   <= 1'b1;
    end else begin
      for (int unsigned g = 0; g < NUM_GROUPS; g++) begin
        state[g]   <= stateNxt[g];
        clrCnt[g]  <= clrNxt[g];
        perCnt[g]  <= perNxt[g];
        fillCnt[g] <= fillNxt[g];
      end
      oSRst_n <= srstNxt;
      oEna    <= enaNxt;
      oValid  <= validNxt;
      oBusy   <= busyNxt;
    end
  end

endmodule

// File: tb/tb_gf_sample_sequencer.sv
// tb_gf_sample_sequencer
//   Self-checking bench for gf_sample_sequencer. A per-group behavioural model
//   (clear countdown, wait-until-pulse countdown, pulse tally) predicts every
//   output each cycle; scenario tasks add directed timing checks.
module tb_gf_sample_sequencer;

  localparam int NG   = 4;
  localparam int CW   = 16;
  localparam int CLR  = 4;
  localparam int FILL = 3;

  logic              iClk = 1'b0;
  logic              iRst;
  logic              iGlobalEna;
  logic [NG*CW-1:0]  iPeriod;
  logic [NG-1:0]     iReinit;
  logic [NG-1:0]     oSRst_n;
  logic [NG-1:0]     oEna;
  logic [NG-1:0]     oValid;
  logic              oBusy;

  int checks = 0;
  int errors = 0;
  int stepNo = 0;

  // Behavioural model state
  int            mActive  [NG];
  int            mClrLeft [NG];
  int            mWait    [NG];
  int            mPulses  [NG];
  logic [NG-1:0] mSrst, mEna, mValid;

  gf_sample_sequencer #(
    .NUM_GROUPS (NG),
    .CNT_WIDTH  (CW),
    .CLR_CYCLES (CLR),
    .FILL_PULSES(FILL)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iGlobalEna(iGlobalEna),
    .iPeriod   (iPeriod),
    .iReinit   (iReinit),
    .oSRst_n   (oSRst_n),
    .oEna      (oEna),
    .oValid    (oValid),
    .oBusy     (oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic setPeriod(input int g, input int p);
    iPeriod[g*CW +: CW] = CW'(p);
  endtask

  task automatic modelReset();
    for (int g = 0; g < NG; g++) begin
      mActive[g]  = 0;
      mClrLeft[g] = CLR;
      mWait[g]    = 0;
      mPulses[g]  = 0;
    end
    mSrst  = '0;
    mEna   = '0;
    mValid = '0;
  endtask

  // Applies the rules for one rising edge, using inputs held since the last negedge.
  task automatic modelEdge();
    logic [NG-1:0] prevEna;
    int p;
    prevEna = mEna;
    for (int g = 0; g < NG; g++) begin
      p = int'(iPeriod[g*CW +: CW]);
      if (iReinit[g]) begin
        mActive[g]  = 0;
        mClrLeft[g] = CLR;
        mSrst[g]    = 1'b0;
        mEna[g]     = 1'b0;
        mValid[g]   = 1'b0;
      end else if (mActive[g] == 0) begin
        mClrLeft[g]--;
        if (mClrLeft[g] == 0) begin
          mActive[g] = 1;
          mSrst[g]   = 1'b1;
          mWait[g]   = p;
          mPulses[g] = 0;
        end
      end else begin
        mEna[g] = 1'b0;
        if (iGlobalEna) begin
          if (prevEna[g] && mPulses[g] < FILL) begin
            mPulses[g]++;
            if (mPulses[g] == FILL) mValid[g] = 1'b1;
          end
          if (mWait[g] == 0) begin
            mEna[g]  = 1'b1;
            mWait[g] = p;
          end else begin
            mWait[g]--;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge iClk);
    modelEdge();
    @(negedge iClk);
    stepNo++;
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    iGlobalEna = 1'b1;
    iReinit = '0;
    iPeriod = '0;
    setPeriod(0, 2);
    setPeriod(1, 0);
    setPeriod(2, 5);
    setPeriod(3, 4);
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    checks++;
    if ({oSRst_n, oEna, oValid, oBusy} !== {4'b0000, 4'b0000, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: got srst=%b ena=%b valid=%b busy=%b want 0000 0000 0000 1",
               oSRst_n, oEna, oValid, oBusy);
    end
    iRst = 1'b0;
    modelReset();
    stepNo = 0;
  endtask

  task automatic test_startup();
    int srst0Rise = -1, srst1Rise = -1, ena0First = -1, valid0 = -1, valid1 = -1, busyFall = -1;
    int ena1Miss = 0;
    for (int s = 1; s <= 30; s++) begin
      step();
      checks++;
      if ({oSRst_n, oEna, oValid, oBusy} !== {mSrst, mEna, mValid, ~&mValid}) begin
        errors++;
        $display("FAIL startup_model step %0d: got srst=%b ena=%b valid=%b busy=%b want srst=%b ena=%b valid=%b busy=%b",
                 s, oSRst_n, oEna, oValid, oBusy, mSrst, mEna, mValid, ~&mValid);
      end
      if (srst0Rise < 0 && oSRst_n[0]) srst0Rise = s;
      if (srst1Rise < 0 && oSRst_n[1]) srst1Rise = s;
      if (ena0First < 0 && oEna[0]) ena0First = s;
      if (valid0 < 0 && oValid[0]) valid0 = s;
      if (valid1 < 0 && oValid[1]) valid1 = s;
      if (busyFall < 0 && !oBusy) busyFall = s;
      if (s >= 5 && !oEna[1]) ena1Miss++;
    end
    checks++;
    if (srst0Rise != 4) begin errors++; $display("FAIL srst0_low_cycles: got rise at %0d want 4", srst0Rise); end
    checks++;
    if (ena0First != 7) begin errors++; $display("FAIL ena0_first_pulse: got %0d want 7", ena0First); end
    checks++;
    if (valid0 != 14) begin errors++; $display("FAIL valid0_rise: got %0d want 14", valid0); end
    checks++;
    if (srst1Rise != 4 || valid1 != 8) begin
      errors++; $display("FAIL valid1_p0: got srst rise %0d valid %0d want 4 8", srst1Rise, valid1);
    end
    checks++;
    if (ena1Miss != 0) begin errors++; $display("FAIL ena1_continuous: got %0d idle cycles want 0", ena1Miss); end
    checks++;
    if (busyFall != 23) begin errors++; $display("FAIL busy_fall: got %0d want 23", busyFall); end
  endtask

  task automatic test_global_gate();
    int t = -1, n = -1, gapPulses = 0, validDrop = 0;
    for (int s = 0; s < 20 && t < 0; s++) begin
      step();
      if (oEna[2]) t = stepNo;
    end
    checks++;
    if (t < 0) begin errors++; $display("FAIL gate_wait_pulse: got none want pulse on group 2"); end
    repeat (2) step();
    iGlobalEna = 1'b0;
    for (int s = 0; s < 10; s++) begin
      step();
      if (oEna != '0) gapPulses++;
      if (!oValid[2]) validDrop++;
      checks++;
      if ({oSRst_n, oEna, oValid, oBusy} !== {mSrst, mEna, mValid, ~&mValid}) begin
        errors++;
        $display("FAIL gate_model step %0d: got ena=%b valid=%b want ena=%b valid=%b", stepNo, oEna, oValid, mEna, mValid);
      end
    end
    iGlobalEna = 1'b1;
    for (int s = 0; s < 20 && n < 0; s++) begin
      step();
      if (oEna[2]) n = stepNo;
      if (!oValid[2]) validDrop++;
    end
    checks++;
    if (gapPulses != 0) begin errors++; $display("FAIL gate_no_pulse: got %0d pulses want 0", gapPulses); end
    checks++;
    if (n - t - 10 != 6) begin errors++; $display("FAIL gate_spacing: got %0d want 6", n - t - 10); end
    checks++;
    if (validDrop != 0) begin errors++; $display("FAIL gate_valid_hold: got %0d drops want 0", validDrop); end
  endtask

  task automatic test_reinit_collision();
    int t = -1, srstRise = -1, validRise = -1, pulses = 0;
    for (int s = 0; s < 20 && t < 0; s++) begin
      step();
      if (oEna[3]) t = stepNo;
    end
    checks++;
    if (t < 0) begin errors++; $display("FAIL reinit_wait_pulse: got none want pulse on group 3"); end
    repeat (4) step();
    iReinit[3] = 1'b1;
    step();
    iReinit[3] = 1'b0;
    checks++;
    if ({oEna[3], oSRst_n[3], oValid[3], oBusy} !== 4'b0001) begin
      errors++;
      $display("FAIL reinit_collision: got ena=%b srst=%b valid=%b busy=%b want 0 0 0 1",
               oEna[3], oSRst_n[3], oValid[3], oBusy);
    end
    checks++;
    if (oValid[2:0] !== 3'b111) begin errors++; $display("FAIL reinit_others: got valid=%b want 111", oValid[2:0]); end
    for (int k = 1; k <= 30; k++) begin
      step();
      checks++;
      if ({oSRst_n, oEna, oValid, oBusy} !== {mSrst, mEna, mValid, ~&mValid}) begin
        errors++;
        $display("FAIL reinit_model step %0d: got srst=%b ena=%b valid=%b busy=%b want srst=%b ena=%b valid=%b busy=%b",
                 k, oSRst_n, oEna, oValid, oBusy, mSrst, mEna, mValid, ~&mValid);
      end
      if (srstRise < 0 && oSRst_n[3]) srstRise = k;
      if (validRise < 0 && oValid[3]) validRise = k;
      if (validRise < 0 && oEna[3]) pulses++;
    end
    checks++;
    if (srstRise != 4 || validRise != 20 || pulses != 3) begin
      errors++;
      $display("FAIL reinit_resequence: got srst rise %0d valid %0d pulses %0d want 4 20 3", srstRise, validRise, pulses);
    end
  endtask

  task automatic test_period_change();
    int t = -1, p1 = -1, p2 = -1, p3 = -1;
    for (int s = 0; s < 20 && t < 0; s++) begin
      step();
      if (oEna[0]) t = stepNo;
    end
    step();
    setPeriod(0, 7);
    for (int s = 0; s < 30 && p3 < 0; s++) begin
      step();
      if (oEna[0]) begin
        if (p1 < 0) p1 = stepNo;
        else if (p2 < 0) p2 = stepNo;
        else p3 = stepNo;
      end
      checks++;
      if (oEna !== mEna) begin errors++; $display("FAIL period_model: got ena=%b want %b", oEna, mEna); end
    end
    checks++;
    if (t < 0 || p3 < 0 || p1 - t != 3 || p2 - p1 != 8 || p3 - p2 != 8) begin
      errors++;
      $display("FAIL period_change: got intervals %0d %0d %0d want 3 8 8", p1 - t, p2 - p1, p3 - p2);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 400; s++) begin
      for (int g = 0; g < NG; g++) begin
        if ($urandom_range(0, 19) == 0) setPeriod(g, int'($urandom_range(0, 6)));
        iReinit[g] = ($urandom_range(0, 39) == 0);
      end
      iGlobalEna = ($urandom_range(0, 4) != 0);
      step();
      checks++;
      if ({oSRst_n, oEna, oValid, oBusy} !== {mSrst, mEna, mValid, ~&mValid}) begin
        errors++;
        $display("FAIL random_model step %0d: got srst=%b ena=%b valid=%b busy=%b want srst=%b ena=%b valid=%b busy=%b",
                 s, oSRst_n, oEna, oValid, oBusy, mSrst, mEna, mValid, ~&mValid);
      end
    end
    iReinit = '0;
    iGlobalEna = 1'b1;
  endtask

  task automatic test_async_reset();
    for (int g = 0; g < NG; g++) setPeriod(g, 3);
    iReinit = '1;
    step();
    iReinit = '0;
    repeat (7) step();
    @(posedge iClk);
    modelEdge();
    #2 iRst = 1'b1;
    #1;
    checks++;
    if ({oSRst_n, oEna, oValid, oBusy} !== {4'b0000, 4'b0000, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got srst=%b ena=%b valid=%b busy=%b want 0000 0000 0000 1",
               oSRst_n, oEna, oValid, oBusy);
    end
    @(negedge iClk);
    iRst = 1'b0;
    modelReset();
    for (int s = 0; s < 30; s++) begin
      step();
      checks++;
      if ({oSRst_n, oEna, oValid, oBusy} !== {mSrst, mEna, mValid, ~&mValid}) begin
        errors++;
        $display("FAIL post_reset_model step %0d: got srst=%b ena=%b valid=%b busy=%b want srst=%b ena=%b valid=%b busy=%b",
                 s, oSRst_n, oEna, oValid, oBusy, mSrst, mEna, mValid, ~&mValid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_global_gate();
    test_reinit_collision();
    test_period_change();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf_sample_sequencer.md
Name: gf_sample_sequencer

Overview:
- Controller for a bank of 3-tap glitch filters: one group = one filter instance.
- Per group, it generates the synchronous-clear (oSRst_n) and the sample-enable pulse (oEna), and flags when the filter output is trustworthy (oValid).
- Sits between the board-level clock domain and the filter instances, so each filter group samples at a programmable rate and is re-initialised on request without a global reset.

Parameters:
- NUM_GROUPS, 4, number of filter groups sequenced.
- CNT_WIDTH, 16, width of each group's sample-period counter.
- CLR_CYCLES, 4, cycles oSRst_n is held low on (re)initialisation; legal range 1..255.
- FILL_PULSES, 3, enable pulses needed to flush the filter pipeline before oValid; legal range 1..15.

Ports:
- iClk, in, 1, core clock; all logic on the rising edge.
- iRst, in, 1, asynchronous active-high reset.
- iGlobalEna, in, 1, 1 = sequencing runs; 0 = period counters and fill counters freeze.
- iPeriod, in, NUM_GROUPS*CNT_WIDTH, group g period P at [g*CNT_WIDTH +: CNT_WIDTH]; pulse spacing is P+1 cycles.
- iReinit, in, NUM_GROUPS, single-cycle request to re-initialise group g.
- oSRst_n, out, NUM_GROUPS, active-low synchronous clear to filter group g.
- oEna, out, NUM_GROUPS, one-cycle sample-enable pulse to filter group g.
- oValid, out, NUM_GROUPS, filter group g output valid.
- oBusy, out, 1, 1 while any group is not in RUN.

Behaviour:
- Reset (iRst=1, asynchronous): all groups enter CLEAR with clear count 0. Outputs: oSRst_n=0, oEna=0, oValid=0, oBusy=1. All outputs are registered.
- Per-group FSM with states CLEAR, FILL and RUN. Groups are fully independent.
- CLEAR:
  - oSRst_n=0, oEna=0, oValid=0.
  - The clear counter increments every cycle, regardless of iGlobalEna.
  - After CLR_CYCLES cycles in CLEAR, the group moves to FILL.
  - On that transition the period counter loads iPeriod[g] and the fill counter is set to 0.
  - After reset release, oSRst_n is low for exactly CLR_CYCLES rising edges.
- FILL and RUN, period counter:
  - oSRst_n=1.
  - With iGlobalEna=1, the counter decrements each cycle.
  - When the counter is 0, oEna[g]=1 in the next cycle and the counter reloads iPeriod[g], sampled at reload time.
  - P=0 gives oEna high every cycle.
  - A change to iPeriod takes effect at the next reload only.
- iGlobalEna=0: the period and fill counters hold, and no new oEna is generated. A pulse already registered still completes its single cycle.
- FILL: the fill counter increments on each oEna cycle. In the cycle after the FILL_PULSES-th oEna cycle, the state is RUN and oValid=1.
- RUN: pulses continue at the programmed rate and oValid stays 1.
- iReinit[g]=1 in any state (including CLEAR): in the next cycle the group is in CLEAR with the clear count restarted, oSRst_n=0, oEna=0 and oValid=0.
  - iReinit has priority over a pulse due in the same cycle; that pulse is suppressed.
  - Holding iReinit high keeps the group in CLEAR.
- oBusy is the registered OR over groups of (state != RUN).
- Counter wrap: the period counter never underflows, because it reloads at 0. The fill counter saturates at FILL_PULSES.
- Mid-operation iRst: immediate return to reset values; no pulse in flight survives.

Test Plan:
- Reset release, CLR_CYCLES=4, iPeriod[0]=2, iGlobalEna=1 -> oSRst_n[0] low for 4 cycles; oEna[0] pulses every 3 cycles, first one 3 cycles after oSRst_n rises; oValid[0] rises the cycle after the 3rd pulse; oBusy falls once all groups are valid.
- iPeriod[1]=0 -> oEna[1] high continuously in FILL/RUN; oValid[1] rises 4 cycles after oSRst_n[1] rises.
- In RUN, group 2 with P=5: drop iGlobalEna for 10 cycles mid-count -> no oEna[2] during the gap; the counter resumes from the held value; spacing excluding the gap is 6 cycles; oValid[2] stays 1.
- iReinit[3] asserted in the same cycle the counter hits 0 -> no oEna[3] pulse; next cycle oSRst_n[3]=0 and oValid[3]=0; full CLEAR/FILL sequence repeats; other groups are unaffected.
- Change iPeriod[0] from 2 to 7 mid-period -> the current interval still ends after 3 cycles; subsequent intervals are 8 cycles.
- Assert iRst asynchronously mid-FILL (between clock edges) -> all outputs return to reset values immediately, without waiting for a clock edge.
